// File: rtl/aso_multi.sv
// Multi-channel amplitude-slope-operator spike detector: |x[n] - x[n-LAG]| against a shared
// threshold, with per-channel refractory windows counted in accepted samples.
module aso_multi #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LAG     = 3,
  parameter int unsigned REFRACT = 500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [NCH*WIDTH-1:0]       data_in,
  input  logic [WIDTH-1:0]           threshold_in,
  input  logic [1:0]                 mode,
  output logic                       spike_valid,
  output logic [NCH-1:0]             spike_detected,
  output logic [NCH-1:0]             in_refractory,
  output logic [NCH*(WIDTH+1)-1:0]   aso_out
);

  localparam int unsigned RcW   = $clog2(REFRACT + 1);
  localparam int unsigned WarmW = $clog2(LAG + 1);

  logic             accept;
  logic             warm;
  logic [WarmW-1:0] warm_q;
  logic             spike_valid_q;

  assign accept      = in_valid && enable;
  assign warm        = (warm_q == WarmW'(LAG));
  assign spike_valid = spike_valid_q;

  // Warm-up saturates once LAG samples sit in history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_q        <= '0;
      spike_valid_q <= 1'b0;
    end else if (!enable) begin
      warm_q        <= '0;
      spike_valid_q <= 1'b0;
    end else if (in_valid) begin
      spike_valid_q <= 1'b1;
      if (!warm) begin
        warm_q <= warm_q + WarmW'(1);
      end
    end else begin
      spike_valid_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] hist_q [LAG];
    logic signed [WIDTH:0]   diff;
    logic        [WIDTH:0]   mag;
    logic        [WIDTH:0]   aso_q;
    logic        [RcW-1:0]   rc_q;
    logic                    hit;
    logic                    fire;
    logic                    det_q;

    assign x = data_in[c*WIDTH +: WIDTH];
    // One extra bit keeps the difference of two full-range samples exact.
    assign diff = {x[WIDTH-1], x} - {hist_q[LAG-1][WIDTH-1], hist_q[LAG-1]};

    always_comb begin
      mag = '0;
      unique case (mode)
        2'b01: if (!diff[WIDTH] && (diff != '0)) mag = diff;
        2'b10: if (diff[WIDTH]) mag = -diff;
        default: mag = diff[WIDTH] ? -diff : diff;
      endcase
    end

    assign hit  = mag > {1'b0, threshold_in};
    assign fire = accept && warm && hit && (rc_q == '0);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hist_q <= '{default: '0};
        rc_q   <= '0;
        aso_q  <= '0;
        det_q  <= 1'b0;
      end else if (!enable) begin
        hist_q <= '{default: '0};
        rc_q   <= '0;
        det_q  <= 1'b0;
      end else if (in_valid) begin
        hist_q[0] <= x;
        for (int i = 1; i < LAG; i++) begin
          hist_q[i] <= hist_q[i-1];
        end
        aso_q <= mag;
        det_q <= fire;
        if (fire) begin
          rc_q <= RcW'(REFRACT);
        end else if (rc_q != '0) begin
          rc_q <= rc_q - RcW'(1);
        end
      end else begin
        det_q <= 1'b0;
      end
    end

    assign spike_detected[c]                  = det_q;
    assign in_refractory[c]                   = (rc_q != '0);
    assign aso_out[c*(WIDTH+1) +: (WIDTH+1)]  = aso_q;
  end

endmodule

// File: tb/tb_aso_multi.sv
// Directed bench for aso_multi: queue-based sample model checked every cycle, plus literal
// expectations for warm-up, refractory, modes, boundary, independence and clearing.
module tb_aso_multi;
  localparam int NCH = 4, WIDTH = 16, LAG = 3, REFRACT = 4;

  logic                     clk = 1'b0;
  logic                     rst_n, enable, in_valid;
  logic [NCH*WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]         threshold_in;
  logic [1:0]               mode;
  logic                     spike_valid;
  logic [NCH-1:0]           spike_detected, in_refractory;
  logic [NCH*(WIDTH+1)-1:0] aso_out;

  aso_multi #(.NCH(NCH), .WIDTH(WIDTH), .LAG(LAG), .REFRACT(REFRACT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .data_in(data_in),
    .threshold_in(threshold_in), .mode(mode), .spike_valid(spike_valid),
    .spike_detected(spike_detected), .in_refractory(in_refractory), .aso_out(aso_out)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history queue per channel (oldest first), accepted-sample count, refractory count.
  int       q[NCH][$];
  int       m_cnt;
  int       m_rc[NCH];
  int       m_aso[NCH];
  bit       m_sv;
  bit [3:0] m_sd;

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      q[c] = {};
      for (int k = 0; k < LAG; k++) q[c].push_back(0);
      m_rc[c] = 0;
    end
    m_cnt = 0;
  endfunction

  always @(posedge clk) begin : model
    int x, d, m;
    bit fire;
    logic [NCH-1:0] exp_ref;
    if (!rst_n) begin
      model_clear();
      for (int c = 0; c < NCH; c++) m_aso[c] = 0;
      m_sv = 0;
      m_sd = '0;
    end else if (!enable) begin
      model_clear();
      m_sv = 0;
      m_sd = '0;
    end else if (in_valid) begin
      m_sv = 1;
      for (int c = 0; c < NCH; c++) begin
        x = int'($signed(data_in[c*WIDTH +: WIDTH]));
        d = x - q[c][0];
        if (mode == 2'b01)      m = (d > 0) ? d : 0;
        else if (mode == 2'b10) m = (d < 0) ? -d : 0;
        else                    m = (d < 0) ? -d : d;
        fire = (m > int'(threshold_in)) && (m_cnt >= LAG) && (m_rc[c] == 0);
        m_sd[c] = fire;
        if (fire) m_rc[c] = REFRACT;
        else if (m_rc[c] > 0) m_rc[c]--;
        m_aso[c] = m;
        void'(q[c].pop_front());
        q[c].push_back(x);
      end
      m_cnt++;
    end else begin
      m_sv = 0;
      m_sd = '0;
    end
    #1;
    for (int c = 0; c < NCH; c++) exp_ref[c] = (m_rc[c] != 0);
    check("model spike_valid", 64'(spike_valid), 64'(m_sv));
    check("model spike_detected", 64'(spike_detected), 64'(m_sd));
    check("model in_refractory", 64'(in_refractory), 64'(exp_ref));
    for (int c = 0; c < NCH; c++)
      check($sformatf("model aso_out[%0d]", c), 64'(aso_out[c*(WIDTH+1) +: (WIDTH+1)]),
            64'(m_aso[c]));
  end

  // Drives one sample at a negedge and returns at the next negedge with outputs updated.
  task automatic send(input int a, input int b, input int c, input int d);
    data_in  = {16'(d), 16'(c), 16'(b), 16'(a)};
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [16:0] aso_ch(input int c);
    return aso_out[c*(WIDTH+1) +: (WIDTH+1)];
  endfunction

  logic [14:0] v_a, v_b;
  logic [3:0]  v4;
  logic [14:0] mode_exp [3];

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; data_in = '0;
    threshold_in = 16'd500; mode = 2'b00;
    mode_exp[0] = 15'b000001000001000;
    mode_exp[1] = 15'b000001000000000;
    mode_exp[2] = 15'b000000000001000;
    @(negedge clk);
    @(negedge clk);
    check("reset spike_valid", 64'(spike_valid), 64'd0);
    check("reset aso_out", 64'(aso_out), 64'd0);
    rst_n = 1'b1;

    // Warm-up on ch0 and refractory on ch1 (square wave hitting every sample).
    for (int i = 0; i < 15; i++) begin
      send((i < 3) ? 0 : 1000, (((i / 3) % 2) == 0) ? 1000 : -1000, 0, 0);
      if (i < 3) check("warmup no spike", 64'(spike_detected), 64'd0);
      if (i == 3) begin
        check("warmup ch0 spike", 64'(spike_detected[0]), 64'd1);
        check("warmup ch0 aso", 64'(aso_ch(0)), 64'd1000);
        check("warmup ch0 refractory", 64'(in_refractory[0]), 64'd1);
      end
      v_a[i] = spike_detected[1];
      v_b[i] = in_refractory[1];
    end
    check("refract ch1 spikes", 64'(v_a), 64'(15'b010000100001000));
    check("refract ch1 window", 64'(v_b), 64'(15'b110111101111000));
    idle();
    check("idle spike_valid low", 64'(spike_valid), 64'd0);
    check("idle spike_detected low", 64'(spike_detected), 64'd0);

    // Mode: ch2 steps 0 -> -800 -> 0 under each mode.
    for (int md = 0; md < 3; md++) begin
      mode = 2'(md);
      for (int i = 0; i < 15; i++) begin
        send(0, 0, (i >= 3 && i < 9) ? -800 : 0, 0);
        v_a[i] = spike_detected[2];
      end
      check($sformatf("mode %0d ch2 spikes", md), 64'(v_a), 64'(mode_exp[md]));
    end
    mode = 2'b00;

    // Boundary: full-scale step on ch3, then same magnitude against threshold 65535.
    for (int i = 0; i < 6; i++) send(0, 0, 0, -32768);
    send(0, 0, 0, 32767);
    check("boundary aso ch3", 64'(aso_ch(3)), 64'd65535);
    check("boundary ch3 fires", 64'(spike_detected[3]), 64'd1);
    for (int i = 0; i < 5; i++) send(0, 0, 0, 32767);
    threshold_in = 16'hffff;
    for (int i = 0; i < 6; i++) send(0, 0, 0, -32768);
    send(0, 0, 0, 32767);
    check("strict threshold ch3", 64'(spike_detected[3]), 64'd0);
    check("strict threshold aso ch3", 64'(aso_ch(3)), 64'd65535);

    // Independence: ch3 in refractory, ch0 and ch2 fire together.
    threshold_in = 16'd500;
    send(0, 0, 0, 0);
    send(1000, 0, -1000, 0);
    check("independent spikes", 64'(spike_detected), 64'(4'b0101));
    check("ch1 refractory untouched", 64'(in_refractory[1]), 64'd0);
    check("ch3 refractory untouched", 64'(in_refractory[3]), 64'd1);

    // Reset mid-refractory with in_valid high.
    rst_n = 1'b0;
    send(5000, 5000, 5000, 5000);
    check("rst spike_valid", 64'(spike_valid), 64'd0);
    check("rst spike_detected", 64'(spike_detected), 64'd0);
    check("rst in_refractory", 64'(in_refractory), 64'd0);
    check("rst aso_out", 64'(aso_out), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send((i < 3) ? 1000 : 0, 0, 0, 0);
      v4[i] = spike_detected[0];
    end
    check("rst warmup restart", 64'(v4), 64'(4'b1000));

    // Soft clear for one cycle with in_valid high.
    enable = 1'b0;
    send(3000, 3000, 3000, 3000);
    check("clear aso retained", 64'(aso_ch(0)), 64'd1000);
    check("clear refractory", 64'(in_refractory), 64'd0);
    check("clear spike_valid", 64'(spike_valid), 64'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send((i < 3) ? 2000 : 0, 0, 0, 0);
      v4[i] = spike_detected[0];
    end
    check("clear warmup restart", 64'(v4), 64'(4'b1000));
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aso_multi.md
# aso_multi

Parametrised, multi-channel successor to the single-channel amplitude-slope-operator (ASO) spike detector. Each of NCH channels computes |x[n] − x[n−LAG]| on every accepted sample. Each channel fires a one-cycle spike flag when the magnitude exceeds a shared programmable threshold. After a spike, a per-channel refractory window counted in samples blocks further spikes. Sits between the sample front-end (sample-rate `in_valid` strobe, not every clock) and the event encoder/output pins.

## Interface
Parameters:
- NCH, 4, number of parallel channels (1..8)
- WIDTH, 16, signed sample width in bits
- LAG, 3, sample distance of the slope difference (1..8)
- REFRACT, 500, refractory length in accepted samples (≥1); counter width $clog2(REFRACT+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  0 = soft clear (history, warm-up, refractory zeroed; no samples accepted)
- in_valid  in  1  one-cycle strobe, data_in holds a new sample for all channels
- data_in  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH], two's complement
- threshold_in  in  WIDTH  unsigned threshold, sampled on each accepted sample
- mode  in  2  00/11 = absolute, 01 = rising only (diff > 0), 10 = falling only (diff < 0); sampled with in_valid
- spike_valid  out  1  one-cycle pulse, one per accepted sample
- spike_detected  out  NCH  per-channel spike flags, meaningful only while spike_valid=1
- in_refractory  out  NCH  per-channel refractory status
- aso_out  out  NCH*(WIDTH+1)  latest unsigned magnitude per channel, held between samples

## Operation
- Accepted sample: `in_valid=1 && enable=1 && rst_n=1`.
- History: per channel, a LAG-deep shift register of past samples. It shifts only on an accepted sample.
- Difference: d = x[n] − x[n−LAG], computed at WIDTH+1 signed bits, so there is no overflow. x[n] is the current data_in, not a registered copy, so there is no extra-sample lag.
- Magnitude per mode:
  - Absolute: m = |d|.
  - Rising: m = d if d>0, else 0.
  - Falling: m = −d if d<0, else 0.
  - m is WIDTH+1 unsigned; |−2^WIDTH| is representable.
- Compare: hit = m > zero-extended threshold_in (strict). threshold_in = 0 fires on any nonzero m.
- Warm-up: per-design counter of accepted samples since reset or soft clear. Detection is suppressed until LAG samples are held in history; the first eligible sample is accepted sample number LAG+1.
- Refractory, per channel (down-counter rc):
  - Spike when hit && warm && rc==0. On a spike, rc loads REFRACT.
  - Otherwise, on each accepted sample where rc>0, rc decrements.
  - in_refractory = (rc != 0).
  - After a spike at sample n, samples n+1 .. n+REFRACT cannot fire; sample n+REFRACT+1 can.
- Channels are fully independent; any subset may fire on the same sample.
- Reset (rst_n=0 at a clock edge): all outputs 0, history 0, warm-up 0, rc 0. Reset wins over in_valid and enable on the same edge.
- Soft clear (enable=0): same internal clearing as reset; spike_valid and spike_detected are 0. aso_out retains its last value.

## Timing
- Latency: spike_valid, spike_detected, aso_out and in_refractory update on the clock edge that accepts the sample. They are visible the cycle after in_valid is asserted.
- spike_valid and spike_detected are high for exactly one cycle, then 0 until the next accepted sample.
- Back-to-back in_valid (every cycle) is supported at full rate; there is no stall and no backpressure.
- in_refractory changes only on accepted-sample edges, reset, or soft clear.
- Reset values: spike_valid=0, spike_detected=0, in_refractory=0, aso_out=0.

## Test plan
- Warm-up, NCH=4, LAG=3, threshold 500, absolute mode. Ch0 samples: 0, 0, 0, 1000.
  - Required: first three spike_valid pulses have spike_detected=0.
  - Required: the fourth has spike_detected[0]=1, aso_out ch0 = 1000, in_refractory[0]=1.
- Refractory, REFRACT=4, ch1 fed a square wave that hits on every sample after warm-up.
  - Required: spikes on samples 4, 9 and 14 only.
  - Required: in_refractory[1] is high for exactly 4 samples after each spike.
- Mode, ch2 step 0 → −800 → 0, threshold 500.
  - Required: absolute mode fires on both edges.
  - Required: mode=01 fires only on the return to 0.
  - Required: mode=10 fires only on the drop.
- Boundary, WIDTH=16, ch3 step −32768 → 32767.
  - Required: aso_out ch3 = 65535, spike fires.
  - Required: the same m with threshold_in=65535 does not fire (strict >).
- Independence, ch0 and ch2 hit on the same sample.
  - Required: spike_detected = 4'b0101; ch1 and ch3 refractory state is unaffected.
- Resets:
  - rst_n=0 while in_valid=1 mid-refractory: all outputs read 0 the next cycle, and warm-up restarts.
  - enable=0 for one cycle: the next LAG samples do not fire, and aso_out is retained.
